// File: rtl/lifo_arbiter.sv
// Round-robin arbiter sharing one LIFO stack among NUM_REQ requesters.
// Tracks occupancy itself and answers overflow/underflow without strobing the stack.
module lifo_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int NUM_REQ    = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_pop,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic                          rsp_err,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [$clog2(DEPTH+1)-1:0]    level,
    output logic                          lifo_wr_enable,
    output logic                          lifo_rd_enable,
    output logic [DATA_WIDTH-1:0]         lifo_data_in,
    input  logic [DATA_WIDTH-1:0]         lifo_data_out
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int LW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t                  r_state;
    logic [IW-1:0]           r_rr;
    logic [IW-1:0]           r_win;
    logic                    r_pop;
    logic [LW-1:0]           r_level;
    logic [NUM_REQ-1:0]      r_rsp_valid;
    logic                    r_rsp_err;
    logic [DATA_WIDTH-1:0]   r_rsp_data;
    logic                    r_wr_en;
    logic                    r_rd_en;
    logic [DATA_WIDTH-1:0]   r_data_in;

    logic                    w_any;
    logic [IW-1:0]           w_win;
    logic [IW-1:0]           w_rr_next;
    logic [NUM_REQ-1:0]      w_grant;
    logic [NUM_REQ-1:0]      w_win_onehot;
    logic [DATA_WIDTH-1:0]   w_push_data;
    logic                    w_win_pop;
    logic                    w_reject;

    // First valid requester at or after the RR pointer, wrapping.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!w_any && req_valid[(32'(r_rr) + k) % NUM_REQ]) begin
                w_any = 1'b1;
                w_win = IW'((32'(r_rr) + k) % NUM_REQ);
            end
        end
    end

    assign w_rr_next    = IW'((32'(w_win) + 1) % NUM_REQ);
    assign w_grant      = NUM_REQ'(1) << w_win;
    assign w_win_onehot = NUM_REQ'(1) << r_win;
    assign w_push_data  = req_data[w_win*DATA_WIDTH +: DATA_WIDTH];
    assign w_win_pop    = req_pop[w_win];
    assign w_reject     = w_win_pop ? (r_level == '0) : (r_level == LW'(DEPTH));

    assign req_ready      = (r_state == IDLE && w_any && !reset) ? w_grant : '0;
    assign rsp_valid      = r_rsp_valid;
    assign rsp_err        = r_rsp_err;
    assign rsp_data       = r_rsp_data;
    assign level          = r_level;
    assign lifo_wr_enable = r_wr_en;
    assign lifo_rd_enable = r_rd_en;
    assign lifo_data_in   = r_data_in;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_rr        <= '0;
            r_win       <= '0;
            r_pop       <= 1'b0;
            r_level     <= '0;
            r_rsp_valid <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_data  <= '0;
            r_wr_en     <= 1'b0;
            r_rd_en     <= 1'b0;
            r_data_in   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_win <= w_win;
                        r_rr  <= w_rr_next;
                        r_pop <= w_win_pop;
                        if (w_reject) begin
                            r_state     <= RESP;
                            r_rsp_valid <= w_grant;
                            r_rsp_err   <= 1'b1;
                            r_rsp_data  <= '0;
                        end else if (w_win_pop) begin
                            r_state <= ISSUE;
                            r_level <= r_level - LW'(1);
                            r_rd_en <= 1'b1;
                        end else begin
                            r_state   <= ISSUE;
                            r_level   <= r_level + LW'(1);
                            r_wr_en   <= 1'b1;
                            r_data_in <= w_push_data;
                        end
                    end
                end
                ISSUE: begin
                    r_wr_en <= 1'b0;
                    r_rd_en <= 1'b0;
                    if (r_pop) begin
                        r_state <= WAIT;
                    end else begin
                        r_state     <= RESP;
                        r_rsp_valid <= w_win_onehot;
                        r_rsp_err   <= 1'b0;
                        r_rsp_data  <= '0;
                    end
                end
                WAIT: begin
                    // Stack output settles the cycle after the rd strobe edge.
                    r_state     <= RESP;
                    r_rsp_valid <= w_win_onehot;
                    r_rsp_err   <= 1'b0;
                    r_rsp_data  <= lifo_data_out;
                end
                RESP: begin
                    r_state     <= IDLE;
                    r_rsp_valid <= '0;
                    r_rsp_err   <= 1'b0;
                    r_rsp_data  <= '0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lifo_arbiter.sv
// Scoreboard bench for lifo_arbiter with a behavioural 16-entry stack attached.
module tb_lifo_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_pop;
    logic [15:0] req_data;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic        rsp_err;
    logic [7:0]  rsp_data;
    logic [4:0]  level;
    logic        lifo_wr_enable;
    logic        lifo_rd_enable;
    logic [7:0]  lifo_data_in;
    logic [7:0]  lifo_data_out;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int         r;
        logic       err;
        logic [7:0] data;
        int         due;
    } exp_t;

    exp_t sb[$];
    int   glog[$];

    lifo_arbiter #(.DATA_WIDTH(8), .DEPTH(16), .NUM_REQ(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_pop(req_pop), .req_data(req_data),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
        .rsp_data(rsp_data), .level(level),
        .lifo_wr_enable(lifo_wr_enable), .lifo_rd_enable(lifo_rd_enable),
        .lifo_data_in(lifo_data_in), .lifo_data_out(lifo_data_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural stack; flags any strobe it would have to refuse.
    logic [7:0] mem [16];
    int         sp;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            sp = 0;
            lifo_data_out <= 8'h00;
        end else begin
            if (lifo_wr_enable) begin
                if (sp == 16) begin
                    n_tests++; n_fail++;
                    $display("FAIL stack_overflow_strobe: got push at sp=%0d required none", sp);
                end else begin
                    mem[sp] = lifo_data_in;
                    sp++;
                end
            end
            if (lifo_rd_enable) begin
                if (sp == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL stack_underflow_strobe: got pop at sp=0 required none");
                end else begin
                    sp--;
                    lifo_data_out <= mem[sp];
                end
            end
        end
    end

    // Monitor: every response pulse must match the oldest scoreboard entry.
    always @(negedge clk) begin
        if (!reset && rsp_valid != 2'b00) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp_valid", 32'(rsp_valid), 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_valid", 32'(rsp_valid), 32'(2'b01 << e.r));
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
                chk("rsp_data", 32'(rsp_data), 32'(e.data));
                chk("rsp_latency_cycle", 32'(cyc), 32'(e.due));
            end
        end
    end

    // Raise a request, wait for its grant, book the expected response, and return
    // at the negedge of the cycle after the accept edge.
    task automatic issue(input int r, input logic pop, input logic [7:0] d,
                         input logic err, input logic [7:0] ed, input int lat);
        bit ok = 0;
        req_pop[r]        = pop;
        req_data[r*8 +: 8] = d;
        req_valid[r]      = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            #1;
            if (req_ready[r]) ok = 1;
            else @(negedge clk);
        end
        if (!ok) begin
            chk("grant_timeout", 32'(r), 32'hFFFF);
            req_valid[r] = 1'b0;
        end else begin
            exp_t e;
            e.r = r; e.err = err; e.data = ed; e.due = cyc + lat;
            sb.push_back(e);
            glog.push_back(r);
            @(negedge clk);
            req_valid[r] = 1'b0;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_pop   = '0;
        req_data  = '0;
        repeat (2) @(negedge clk);
        chk("reset_level", 32'(level), 0);
        chk("reset_rsp_valid", 32'(rsp_valid), 0);
        chk("reset_strobes", 32'({lifo_wr_enable, lifo_rd_enable}), 0);
        reset = 1'b0;
        @(negedge clk);

        // 1: single push
        glog.delete();
        issue(0, 1'b0, 8'hA1, 1'b0, 8'h00, 2);
        chk("t1_grant", 32'(glog[0]), 0);
        chk("t1_wr_strobe", 32'(lifo_wr_enable), 1);
        chk("t1_data_in", 32'(lifo_data_in), 32'hA1);
        chk("t1_level", 32'(level), 1);
        @(negedge clk);
        chk("t1_wr_strobe_drop", 32'(lifo_wr_enable), 0);
        repeat (2) @(negedge clk);

        // 2: simultaneous pushes, then two pops by r1
        pulse_reset();
        glog.delete();
        fork
            issue(0, 1'b0, 8'h11, 1'b0, 8'h00, 2);
            issue(1, 1'b0, 8'h22, 1'b0, 8'h00, 2);
        join
        chk("t2_first_grant", 32'(glog[0]), 0);
        chk("t2_second_grant", 32'(glog[1]), 1);
        issue(1, 1'b1, 8'h00, 1'b0, 8'h22, 3);
        chk("t2_rd_strobe", 32'(lifo_rd_enable), 1);
        issue(1, 1'b1, 8'h00, 1'b0, 8'h11, 3);
        chk("t2_level", 32'(level), 0);
        repeat (4) @(negedge clk);

        // 3: pop on empty
        issue(1, 1'b1, 8'h00, 1'b1, 8'h00, 1);
        chk("t3_no_rd_strobe", 32'(lifo_rd_enable), 0);
        chk("t3_level", 32'(level), 0);
        repeat (2) @(negedge clk);

        // 4: fill, overflow, pop top
        for (int i = 0; i < 16; i++) issue(0, 1'b0, 8'(i), 1'b0, 8'h00, 2);
        repeat (2) @(negedge clk);
        chk("t4_level_full", 32'(level), 16);
        issue(0, 1'b0, 8'hFF, 1'b1, 8'h00, 1);
        chk("t4_no_wr_strobe", 32'(lifo_wr_enable), 0);
        chk("t4_level_after_err", 32'(level), 16);
        repeat (1) @(negedge clk);
        issue(0, 1'b1, 8'h00, 1'b0, 8'h0F, 3);
        chk("t4_level_after_pop", 32'(level), 15);
        repeat (4) @(negedge clk);

        // 5: round-robin with both requesters holding pushes
        pulse_reset();
        glog.delete();
        fork
            begin
                issue(0, 1'b0, 8'h50, 1'b0, 8'h00, 2);
                issue(0, 1'b0, 8'h51, 1'b0, 8'h00, 2);
            end
            begin
                issue(1, 1'b0, 8'h60, 1'b0, 8'h00, 2);
                issue(1, 1'b0, 8'h61, 1'b0, 8'h00, 2);
            end
        join
        repeat (3) @(negedge clk);
        chk("t5_grant_count", 32'(glog.size()), 4);
        if (glog.size() == 4) begin
            chk("t5_order0", 32'(glog[0]), 0);
            chk("t5_order1", 32'(glog[1]), 1);
            chk("t5_order2", 32'(glog[2]), 0);
            chk("t5_order3", 32'(glog[3]), 1);
        end
        chk("t5_level", 32'(level), 4);

        // 6: reset during WAIT of a pop; no response may follow
        req_pop[0]   = 1'b1;
        req_valid[0] = 1'b1;
        #1;
        chk("t6_grant", 32'(req_ready), 32'b01);
        @(negedge clk);
        req_valid[0] = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_async_level", 32'(level), 0);
        chk("t6_async_rsp", 32'({rsp_valid, rsp_err, rsp_data}), 0);
        chk("t6_async_strobes", 32'({lifo_wr_enable, lifo_rd_enable, lifo_data_in}), 0);
        chk("t6_async_ready", 32'(req_ready), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        chk("t6_level_after", 32'(level), 0);
        chk("scoreboard_drained", 32'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
